// File: rtl/cla_9bit_pkg.sv
// rtl/cla_9bit_pkg.sv - shared widths for the registered 8-bit carry-lookahead adder
package cla_9bit_pkg;
  localparam int CLA_W   = 8;
  localparam int CLA_GRP = 4;
endpackage

// File: rtl/cla_9bit_if.sv
// rtl/cla_9bit_if.sv - operand/result bundle for cla_9bit
interface cla_9bit_if;
  import cla_9bit_pkg::*;

  logic [CLA_W-1:0] A;
  logic [CLA_W-1:0] B;
  logic             Ci;
  logic [CLA_W:0]   Sum;
  logic             Co;

  // Driver of operands, consumer of the registered result
  modport master (output A, output B, output Ci, input Sum, input Co);
  // The adder itself
  modport slave  (input A, input B, input Ci, output Sum, output Co);
endinterface

// File: rtl/cla_4bit_grp.sv
// rtl/cla_4bit_grp.sv - 4-bit lookahead group: sum bits plus group generate/propagate
module cla_4bit_grp
  import cla_9bit_pkg::*;
(
  input  logic [CLA_GRP-1:0] a,
  input  logic [CLA_GRP-1:0] b,
  input  logic               cin,
  output logic [CLA_GRP-1:0] s,
  output logic               G,
  output logic               P
);
  logic [CLA_GRP-1:0] g;
  logic [CLA_GRP-1:0] p;
  logic [CLA_GRP-1:0] c;

  // Every internal carry is a flat sum-of-products of g/p/cin, so no carry
  // depends on another carry and the group has no ripple path.
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    s    = p ^ c;
    G    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    P    = &p;
  end
endmodule

// File: rtl/cla_9bit.sv
// rtl/cla_9bit.sv - registered A+B+Ci using two lookahead groups and a second-level carry unit
module cla_9bit
  import cla_9bit_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  cla_9bit_if.slave bus
);
  logic [CLA_GRP-1:0] s_lo;
  logic [CLA_GRP-1:0] s_hi;
  logic               g_lo;
  logic               p_lo;
  logic               g_hi;
  logic               p_hi;
  logic               c4;
  logic               c8;
  logic [CLA_W:0]     sum_q;

  // Second-level lookahead: both group carries come straight from G/P and Ci.
  always_comb begin
    c4 = g_lo | (p_lo & bus.Ci);
    c8 = g_hi | (p_hi & g_lo) | (p_hi & p_lo & bus.Ci);
  end

  cla_4bit_grp u_grp_lo (
    .a   (bus.A[CLA_GRP-1:0]),
    .b   (bus.B[CLA_GRP-1:0]),
    .cin (bus.Ci),
    .s   (s_lo),
    .G   (g_lo),
    .P   (p_lo)
  );

  cla_4bit_grp u_grp_hi (
    .a   (bus.A[CLA_W-1:CLA_GRP]),
    .b   (bus.B[CLA_W-1:CLA_GRP]),
    .cin (c4),
    .s   (s_hi),
    .G   (g_hi),
    .P   (p_hi)
  );

  // Result register; Co is taken from the same flop as Sum[8] so the two can never disagree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= {c8, s_hi, s_lo};
    end
  end

  assign bus.Sum = sum_q;
  assign bus.Co  = sum_q[CLA_W];
endmodule

// File: tb/tb_cla_9bit.sv
// tb/tb_cla_9bit.sv - self-checking bench for cla_9bit
module tb_cla_9bit;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int errors = 0;

  cla_9bit_if bus ();

  cla_9bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [8:0] exp;
  } vec_t;

  typedef struct {
    logic [8:0] exp;
    string      name;
  } sb_t;

  vec_t vecs[8];
  sb_t  sb[$];

  task automatic check(input string name, input logic [8:0] exp);
    checks++;
    if (bus.Sum !== exp) begin
      errors++;
      $display("FAIL %s: Sum=%h expected %h", name, bus.Sum, exp);
    end
    checks++;
    if (bus.Co !== exp[8]) begin
      errors++;
      $display("FAIL %s: Co=%b expected %b", name, bus.Co, exp[8]);
    end
  endtask

  // Called at a falling edge: compare the result registered at the previous
  // rising edge, then drive the next vector and queue its expected result.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic ci,
                       input string name);
    sb_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.name, e.exp);
    end
    bus.A  = a;
    bus.B  = b;
    bus.Ci = ci;
    e.exp  = 9'(a) + 9'(b) + 9'(ci);
    e.name = name;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic drain();
    sb_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.name, e.exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1);
  end

  initial begin
    int rst_at;
    logic [7:0] ra, rb;
    logic rc;

    vecs[0] = '{8'hFE, 8'h01, 1'b1, 9'h100};
    vecs[1] = '{8'h0F, 8'h01, 1'b0, 9'h010};
    vecs[2] = '{8'h0F, 8'h00, 1'b1, 9'h010};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 9'h000};
    vecs[4] = '{8'h55, 8'hAA, 1'b0, 9'h0FF};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 9'h1FF};
    vecs[6] = '{8'h80, 8'h80, 1'b0, 9'h100};
    vecs[7] = '{8'h7F, 8'h01, 1'b0, 9'h080};

    // Reset asserted before the first rising edge: outputs clear without a clock.
    bus.A  = 8'hFF;
    bus.B  = 8'hFF;
    bus.Ci = 1'b1;
    #1 rst_n = 1'b0;
    #2 check("reset_async", 9'h000);
    repeat (3) @(negedge clk);
    check("reset_hold", 9'h000);

    // Release: the first rising edge registers FF+FF+1.
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("release", 9'h1FF);

    // Table vectors, one per cycle, with constant expected results.
    for (int i = 0; i < 8; i++) begin
      bus.A  = vecs[i].a;
      bus.B  = vecs[i].b;
      bus.Ci = vecs[i].ci;
      @(negedge clk);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Back-to-back pipelined stream from the scoreboard, reset at a random point.
    rst_at = $urandom_range(100, 900);
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      if (i == rst_at) begin
        issue(8'hFF, 8'hFF, 1'b1, "pre_reset");
        issue(8'hFF, 8'hFF, 1'b1, "pending");
        #2 rst_n = 1'b0;
        #1 check("reset_midstream", 9'h000);
        sb.delete();
        @(negedge clk);
        check("reset_mid_hold", 9'h000);
        rst_n = 1'b1;
      end
      issue(ra, rb, rc, $sformatf("rand%0d", i));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cla_9bit.md
# cla_9bit

Registered 8-bit carry-lookahead adder producing a 9-bit result (8-bit sum plus carry-out) and a separate carry-out flag. It sits on the datapath wherever a fast A+B+Ci with a registered result is needed. Internally it uses two 4-bit lookahead groups joined by a second-level lookahead carry unit; no ripple chain is permitted.

## Interface
- No parameters; widths are fixed (operand 8 bits, result 9 bits).
- clk    input   1   single clock; all state updates on rising edge
- rst_n  input   1   reset, asynchronous, active-low
- A      input   8   operand A, unsigned
- B      input   8   operand B, unsigned
- Ci     input   1   carry-in
- Sum    output  9   registered result, A + B + Ci
- Co     output  1   registered carry-out of bit 7

## Operation
- Per bit: g[i] = A[i] & B[i], p[i] = A[i] ^ B[i], s[i] = p[i] ^ c[i], with c[0] = Ci.
- Group k (bits 4k..4k+3):
  - Internal carries come from full lookahead expressions, e.g. c1 = g0 | p0·c0 and c2 = g1 | p1·g0 | p1·p0·c0.
  - Group generate: G = g3 | p3·g2 | p3·p2·g1 | p3·p2·p1·g0.
  - Group propagate: P = p3·p2·p1·p0.
- Second level: c4 = G0 | P0·Ci; c8 = G1 | P1·G0 | P1·P0·Ci.
- Next-state result: Sum = {c8, s[7:0]}; Co = c8. Sum[8] equals Co in every cycle, including during and after reset.
- Arithmetic is unsigned, mod 2^9 is never exceeded: the maximum is 255+255+1 = 511 = 9'h1FF.
- No signed overflow flag is produced.

## Timing
- Latency is 1 cycle. Inputs sampled at rising edge N appear on Sum/Co after edge N.
- Throughput is one add per cycle; there is no handshake and no valid signal.
- Reset: rst_n low forces Sum = 9'h000 and Co = 0 immediately, without waiting for clk. Both outputs hold while rst_n is low.
- Release: the first rising edge with rst_n high registers the current inputs.
- Reset asserted mid-stream discards the pending result. No state survives reset.
- Inputs must be stable across the setup/hold window of clk. The combinational path A/B/Ci → register is two lookahead levels deep.

## Structure
- Shared package: constant CLA_W = 8 and constant CLA_GRP = 4. No typedefs are needed.
- One sub-module, cla_4bit_grp:
  - Inputs: a[3:0], b[3:0], cin.
  - Outputs: s[3:0], G, P.
  - Instantiated twice.
- Second-level carry logic and the output register live in the top module.

## Test plan
- Reset: drive rst_n=0 with A=8'hFF, B=8'hFF, Ci=1 → Sum=9'h000, Co=0 asynchronously. After release plus one edge → Sum=9'h1FF, Co=1.
- Carry through all bits: A=8'hFE, B=8'h01, Ci=1 → after one edge Sum=9'h100, Co=1.
- Group boundary: A=8'h0F, B=8'h01, Ci=0 → Sum=9'h010, Co=0. Then A=8'h0F, B=8'h00, Ci=1 → Sum=9'h010, Co=0.
- Zero and no carry: A=8'h00, B=8'h00, Ci=0 → Sum=9'h000, Co=0. Then A=8'h55, B=8'hAA, Ci=0 → Sum=9'h0FF, Co=0.
- Back-to-back pipelining: apply a new vector every cycle → each result appears exactly one cycle later and matches A+B+Ci.
- Random regression: 1000 random A/B/Ci vectors → Sum == A+B+Ci and Co == Sum[8] on every cycle. Also assert rst_n at a random mid-stream point → outputs go to 0 immediately.
